// File: rtl/wb_select_reg_if.sv
// Write-back selector bus: request, source selection, packed sources and
// the registered write-port result returned to the requester.
interface wb_select_reg_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 6,
  parameter int SELW  = 3
);
  logic                    req;
  logic [SELW-1:0]         sel;
  logic [2:0]              ext;
  logic [4:0]              dest;
  logic [NSRC*WIDTH-1:0]   src_bus;
  logic                    err_clr;
  logic [WIDTH-1:0]        wb_data;
  logic [4:0]              wb_dest;
  logic                    wb_valid;
  logic                    sel_err;

  // Requester side: drives the request and sources, observes the result.
  modport master (
    output req, sel, ext, dest, src_bus, err_clr,
    input  wb_data, wb_dest, wb_valid, sel_err
  );

  // Selector side: samples the request, returns the registered result.
  modport slave (
    input  req, sel, ext, dest, src_bus, err_clr,
    output wb_data, wb_dest, wb_valid, sel_err
  );
endinterface

// File: rtl/wb_select_reg.sv
// Registered write-back source selector. Picks one of NSRC packed source
// buses, applies a sub-word extension and presents the result with its
// destination index and a one-cycle valid pulse. Out-of-range selects never
// write: outputs hold and a sticky error flag is raised.
module wb_select_reg #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 6,
  parameter int SELW  = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  wb_select_reg_if.slave  bus
);

  // Implicit valid-pulse FSM: VALID lasts exactly one cycle per accept.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  // Source count widened by one bit so NSRC == 2**SELW still compares cleanly.
  localparam logic [SELW:0] NSRC_L = (SELW+1)'(NSRC);

  // Sub-word extension of the selected source. Built from a full-width
  // scratch word so that WIDTH == 16 needs no zero-length replication.
  function automatic logic [WIDTH-1:0] ext_apply(
    input logic [2:0]       mode,
    input logic [WIDTH-1:0] s
  );
    logic [WIDTH-1:0] r;
    r = s;
    case (mode)
      3'b001: begin
        r       = s[7] ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        r[7:0]  = s[7:0];
      end
      3'b010: begin
        r       = {WIDTH{1'b0}};
        r[7:0]  = s[7:0];
      end
      3'b011: begin
        r       = s[15] ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        r[15:0] = s[15:0];
      end
      3'b100: begin
        r       = {WIDTH{1'b0}};
        r[15:0] = s[15:0];
      end
      3'b101: begin
        r       = {WIDTH{1'b0}};
        r[15:0] = s[15:0];
        r       = r << (WIDTH - 16);
      end
      // 000 passes through; 110/111 are reserved and behave as 000.
      default: begin
        r = s;
      end
    endcase
    return r;
  endfunction

  logic              sel_ok_s;
  logic              accept_s;
  logic              reject_s;
  logic [WIDTH-1:0]  selected_s;
  logic [WIDTH-1:0]  ext_data_s;
  logic [0:0]        state_next_s;

  logic [WIDTH-1:0]  wb_data_r;
  logic [4:0]        wb_dest_r;
  logic [0:0]        state_r;
  logic              sel_err_r;

  // Classify the request as accept, reject or idle.
  always_comb begin
    sel_ok_s = ({1'b0, bus.sel} < NSRC_L);
    accept_s = bus.req & sel_ok_s;
    reject_s = bus.req & ~sel_ok_s;
  end

  // Source mux; an out-of-range select yields zero but is never written.
  always_comb begin
    selected_s = {WIDTH{1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      if (bus.sel == SELW'(i)) begin
        selected_s = bus.src_bus[i*WIDTH +: WIDTH];
      end else begin
        selected_s = selected_s;
      end
    end
  end

  // Apply the requested extension to the selected source.
  always_comb begin
    ext_data_s = ext_apply(bus.ext, selected_s);
  end

  // Valid-pulse next state: every accept (including back-to-back) enters VALID.
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_next_s = ST_VALID;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_VALID: begin
        if (accept_s) begin
          state_next_s = ST_VALID;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Result registers: load on accept, otherwise hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_data_r <= {WIDTH{1'b0}};
      wb_dest_r <= 5'd0;
    end else if (accept_s) begin
      wb_data_r <= ext_data_s;
      wb_dest_r <= bus.dest;
    end else begin
      wb_data_r <= wb_data_r;
      wb_dest_r <= wb_dest_r;
    end
  end

  // Valid-pulse state register; reset kills a pending pulse immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sticky select error: a reject beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_err_r <= 1'b0;
    end else if (reject_s) begin
      sel_err_r <= 1'b1;
    end else if (bus.err_clr) begin
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

  assign bus.wb_data  = wb_data_r;
  assign bus.wb_dest  = wb_dest_r;
  assign bus.wb_valid = state_r[0];
  assign bus.sel_err  = sel_err_r;

endmodule

// File: tb/tb_wb_select_reg.sv
// Self-checking bench for wb_select_reg: directed scenarios plus a randomized
// run checked against an arithmetic reference model.
module tb_wb_select_reg;
  localparam int WIDTH = 32;
  localparam int NSRC  = 6;
  localparam int SELW  = 3;

  logic clk = 1'b0;
  logic reset_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  logic [31:0] src [NSRC];

  // Reference model state (what the outputs must show after each edge).
  logic [31:0] exp_data;
  logic [4:0]  exp_dest;
  logic        exp_valid;
  logic        exp_err;

  wb_select_reg_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) bus ();

  wb_select_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Extension rules expressed arithmetically on the numeric value.
  function automatic logic [31:0] ref_ext(input logic [2:0] mode, input logic [31:0] s);
    longint unsigned v;
    longint unsigned x;
    x = 64'(s);
    case (mode)
      3'd1: begin v = x % 64'd256;   if (v >= 64'd128)   v = v + 64'hFFFF_FF00; end
      3'd2: begin v = x % 64'd256; end
      3'd3: begin v = x % 64'd65536; if (v >= 64'd32768) v = v + 64'hFFFF_0000; end
      3'd4: begin v = x % 64'd65536; end
      3'd5: begin v = (x % 64'd65536) * 64'd65536; end
      default: begin v = x; end
    endcase
    return v[31:0];
  endfunction

  task automatic model_reset();
    exp_data  = 32'd0;
    exp_dest  = 5'd0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model, then wait past the edge.
  task automatic drive(input logic r, input logic [2:0] s, input logic [2:0] e,
                       input logic [4:0] d, input logic c);
    bus.req     = r;
    bus.sel     = s;
    bus.ext     = e;
    bus.dest    = d;
    bus.err_clr = c;
    for (int i = 0; i < NSRC; i++) bus.src_bus[i*WIDTH +: WIDTH] = src[i];
    if (r && (int'(s) < NSRC)) begin
      exp_data  = ref_ext(e, src[int'(s)]);
      exp_dest  = d;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
    if (r && (int'(s) >= NSRC)) exp_err = 1'b1;
    else if (c)                 exp_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    src[0] = 32'h1234_5678;
    for (int i = 1; i < NSRC; i++) src[i] = 32'd0;
    model_reset();
    bus.req = 1'b1; bus.sel = 3'd0; bus.ext = 3'd0; bus.dest = 5'd9; bus.err_clr = 1'b0;
    for (int i = 0; i < NSRC; i++) bus.src_bus[i*WIDTH +: WIDTH] = src[i];
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_hold: got v=%0b dest=%0d data=%h err=%0b, expected all zero",
               bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 3'd0, 3'd0, 5'd9, 1'b0);
    tests_run++;
    if ({bus.wb_valid, bus.wb_dest, bus.wb_data} !== {1'b1, 5'd9, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL first_accept: got v=%0b dest=%0d data=%h, expected v=1 dest=9 data=12345678",
               bus.wb_valid, bus.wb_dest, bus.wb_data);
    end
    drive(1'b0, 3'd0, 3'd0, 5'd0, 1'b0);
    tests_run++;
    if ({bus.wb_valid, bus.wb_dest, bus.wb_data} !== {1'b0, 5'd9, 32'h1234_5678}) begin
      tests_failed++;
      $display("FAIL pulse_end: got v=%0b dest=%0d data=%h, expected v=0 dest=9 data=12345678",
               bus.wb_valid, bus.wb_dest, bus.wb_data);
    end
  endtask

  task automatic test_select_sweep();
    logic [31:0] want;
    for (int i = 0; i < NSRC; i++) src[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < NSRC; i++) begin
      drive(1'b1, 3'(i), 3'd0, 5'(i + 1), 1'b0);
      want = 32'hA000_0000 + 32'(i);
      tests_run++;
      if ({bus.wb_valid, bus.wb_dest, bus.wb_data} !== {1'b1, 5'(i + 1), want}) begin
        tests_failed++;
        $display("FAIL sweep[%0d]: got v=%0b dest=%0d data=%h, expected v=1 dest=%0d data=%h",
                 i, bus.wb_valid, bus.wb_dest, bus.wb_data, i + 1, want);
      end
    end
  endtask

  task automatic test_extension();
    logic [31:0] table_exp [8];
    table_exp[0] = 32'h0000_8F80; table_exp[1] = 32'hFFFF_FF80;
    table_exp[2] = 32'h0000_0080; table_exp[3] = 32'hFFFF_8F80;
    table_exp[4] = 32'h0000_8F80; table_exp[5] = 32'h8F80_0000;
    table_exp[6] = 32'h0000_8F80; table_exp[7] = 32'h0000_8F80;
    src[2] = 32'h0000_8F80;
    for (int e = 0; e < 8; e++) begin
      drive(1'b1, 3'd2, 3'(e), 5'd17, 1'b0);
      tests_run++;
      if ({bus.wb_valid, bus.wb_data, bus.sel_err} !== {1'b1, table_exp[e], 1'b0}) begin
        tests_failed++;
        $display("FAIL ext[%0d]: got v=%0b data=%h err=%0b, expected v=1 data=%h err=0",
                 e, bus.wb_valid, bus.wb_data, bus.sel_err, table_exp[e]);
      end
    end
  endtask

  task automatic test_invalid_select();
    src[0] = 32'h0000_0055;
    drive(1'b1, 3'd0, 3'd0, 5'd3, 1'b0);
    tests_run++;
    if ({bus.wb_valid, bus.wb_data} !== {1'b1, 32'h55}) begin
      tests_failed++;
      $display("FAIL inv_setup: got v=%0b data=%h, expected v=1 data=00000055", bus.wb_valid, bus.wb_data);
    end
    for (int s = 6; s < 8; s++) begin
      drive(1'b1, 3'(s), 3'd0, 5'd30, 1'b0);
      tests_run++;
      if ({bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err} !== {1'b0, 5'd3, 32'h55, 1'b1}) begin
        tests_failed++;
        $display("FAIL invalid_sel[%0d]: got v=%0b dest=%0d data=%h err=%0b, expected v=0 dest=3 data=00000055 err=1",
                 s, bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err);
      end
    end
    drive(1'b0, 3'd0, 3'd0, 5'd0, 1'b1);
    tests_run++;
    if ({bus.sel_err, bus.wb_data} !== {1'b0, 32'h55}) begin
      tests_failed++;
      $display("FAIL err_clear: got err=%0b data=%h, expected err=0 data=00000055", bus.sel_err, bus.wb_data);
    end
  endtask

  task automatic test_clear_collision();
    drive(1'b1, 3'd7, 3'd0, 5'd1, 1'b1);
    tests_run++;
    if ({bus.sel_err, bus.wb_valid} !== {1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL collision: got err=%0b v=%0b, expected err=1 v=0", bus.sel_err, bus.wb_valid);
    end
    drive(1'b0, 3'd0, 3'd0, 5'd0, 1'b1);
    tests_run++;
    if (bus.sel_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL collision_clear: got err=%0b, expected err=0", bus.sel_err);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NSRC; i++) src[i] = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 7) == 0));
      tests_run++;
      if ({bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err} !== {exp_valid, exp_dest, exp_data, exp_err}) begin
        tests_failed++;
        $display("FAIL random[%0d]: got v=%0b dest=%0d data=%h err=%0b, expected v=%0b dest=%0d data=%h err=%0b",
                 n, bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err,
                 exp_valid, exp_dest, exp_data, exp_err);
      end
    end
  endtask

  task automatic test_async_reset();
    src[1] = 32'hDEAD_BEEF;
    drive(1'b1, 3'd1, 3'd0, 5'd4, 1'b0);
    tests_run++;
    if ({bus.wb_valid, bus.wb_data} !== {1'b1, 32'hDEAD_BEEF}) begin
      tests_failed++;
      $display("FAIL async_setup: got v=%0b data=%h, expected v=1 data=deadbeef", bus.wb_valid, bus.wb_data);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_kill: got v=%0b dest=%0d data=%h err=%0b, expected all zero",
               bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL async_hold: got v=%0b dest=%0d data=%h err=%0b, expected all zero with req=1",
               bus.wb_valid, bus.wb_dest, bus.wb_data, bus.sel_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    src[3] = 32'h0BAD_F00D;
    drive(1'b1, 3'd3, 3'd0, 5'd7, 1'b0);
    tests_run++;
    if ({bus.wb_valid, bus.wb_dest, bus.wb_data} !== {1'b1, 5'd7, 32'h0BAD_F00D}) begin
      tests_failed++;
      $display("FAIL post_reset_accept: got v=%0b dest=%0d data=%h, expected v=1 dest=7 data=0badf00d",
               bus.wb_valid, bus.wb_dest, bus.wb_data);
    end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_extension();
    test_invalid_select();
    test_clear_collision();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
